// File: rtl/ram_arbiter.sv
// Two-port arbiter for a single-port RAM with one-cycle registered read; IDLE->ACCESS->WAIT, ack in the cycle after WAIT.
// Optional B-port write protection over [WP_LO..WP_HI] enabled by defining RAM_ARB_WPROT_EN.
module ram_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int PRIO_MODE = 0
`ifdef RAM_ARB_WPROT_EN
  ,
  parameter logic [ADDR_W-1:0] WP_LO = 16'hF000,
  parameter logic [ADDR_W-1:0] WP_HI = 16'hFFFF
`endif
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_a_req,
  input  logic              i_a_we,
  input  logic [ADDR_W-1:0] i_a_addr,
  input  logic [DATA_W-1:0] i_a_dat,
  output logic [DATA_W-1:0] o_a_dat,
  output logic              o_a_ack,
  input  logic              i_b_req,
  input  logic              i_b_we,
  input  logic [ADDR_W-1:0] i_b_addr,
  input  logic [DATA_W-1:0] i_b_dat,
  output logic [DATA_W-1:0] o_b_dat,
  output logic              o_b_ack,
  output logic              o_b_err,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_ram_dat,
  output logic              o_ram_we,
  output logic              o_ram_cs,
  input  logic [DATA_W-1:0] i_ram_dat
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]   ram_dat_q, ram_dat_d;
  logic                ram_we_q, ram_we_d;
  logic                ram_cs_q, ram_cs_d;
  logic [DATA_W-1:0]   a_dat_q, a_dat_d;
  logic [DATA_W-1:0]   b_dat_q, b_dat_d;
  logic                a_ack_q, a_ack_d;
  logic                b_ack_q, b_ack_d;
  // Doubles as the owner of the in-flight access; reset to B so A wins the first tie.
  logic                last_b_q, last_b_d;
  logic                pick_b;
  logic                wp_hit;
`ifdef RAM_ARB_WPROT_EN
  logic                err_pend_q, err_pend_d;
  logic                b_err_q, b_err_d;
`endif

`ifdef RAM_ARB_WPROT_EN
  assign wp_hit = i_b_we && (i_b_addr >= WP_LO) && (i_b_addr <= WP_HI);
`else
  assign wp_hit = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    ram_addr_d = ram_addr_q;
    ram_dat_d  = ram_dat_q;
    ram_we_d   = 1'b0;
    ram_cs_d   = 1'b0;
    a_dat_d    = a_dat_q;
    b_dat_d    = b_dat_q;
    a_ack_d    = 1'b0;
    b_ack_d    = 1'b0;
    last_b_d   = last_b_q;
    pick_b     = 1'b0;
`ifdef RAM_ARB_WPROT_EN
    err_pend_d = err_pend_q;
    b_err_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (i_a_req || i_b_req) begin
          if (i_a_req && i_b_req)
            pick_b = (PRIO_MODE == 0) ? !last_b_q : 1'b0;
          else
            pick_b = i_b_req;
          last_b_d   = pick_b;
          ram_addr_d = pick_b ? i_b_addr : i_a_addr;
          ram_dat_d  = pick_b ? i_b_dat  : i_a_dat;
          ram_we_d   = pick_b ? i_b_we   : i_a_we;
          ram_cs_d   = 1'b1;
          // A protected B write runs the normal sequence but never selects the RAM.
          if (pick_b && wp_hit) begin
            ram_we_d = 1'b0;
            ram_cs_d = 1'b0;
          end
`ifdef RAM_ARB_WPROT_EN
          err_pend_d = pick_b && wp_hit;
`endif
          state_d = ACCESS;
        end
      end
      ACCESS: state_d = WAIT;
      WAIT: begin
        if (last_b_q) begin
          b_dat_d = i_ram_dat;
          b_ack_d = 1'b1;
`ifdef RAM_ARB_WPROT_EN
          b_err_d = err_pend_q;
`endif
        end else begin
          a_dat_d = i_ram_dat;
          a_ack_d = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= IDLE;
      ram_addr_q <= '0;
      ram_dat_q  <= '0;
      ram_we_q   <= 1'b0;
      ram_cs_q   <= 1'b0;
      a_dat_q    <= '0;
      b_dat_q    <= '0;
      a_ack_q    <= 1'b0;
      b_ack_q    <= 1'b0;
      last_b_q   <= 1'b1;
`ifdef RAM_ARB_WPROT_EN
      err_pend_q <= 1'b0;
      b_err_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      ram_addr_q <= ram_addr_d;
      ram_dat_q  <= ram_dat_d;
      ram_we_q   <= ram_we_d;
      ram_cs_q   <= ram_cs_d;
      a_dat_q    <= a_dat_d;
      b_dat_q    <= b_dat_d;
      a_ack_q    <= a_ack_d;
      b_ack_q    <= b_ack_d;
      last_b_q   <= last_b_d;
`ifdef RAM_ARB_WPROT_EN
      err_pend_q <= err_pend_d;
      b_err_q    <= b_err_d;
`endif
    end
  end

  assign o_ram_addr = ram_addr_q;
  assign o_ram_dat  = ram_dat_q;
  assign o_ram_we   = ram_we_q;
  assign o_ram_cs   = ram_cs_q;
  assign o_a_dat    = a_dat_q;
  assign o_b_dat    = b_dat_q;
  assign o_a_ack    = a_ack_q;
  assign o_b_ack    = b_ack_q;
`ifdef RAM_ARB_WPROT_EN
  assign o_b_err    = b_err_q;
`else
  assign o_b_err    = 1'b0;
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench: round-robin instance (u0) and fixed-priority instance (u1) share the requester inputs, each with its own RAM model.
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_init = 1'b1;
  logic        a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [15:0] a_addr = '0, a_dat = '0, b_addr = '0, b_dat = '0;

  logic [15:0] a_dat0, b_dat0, ram_addr0, ram_dat0, rdat0;
  logic        a_ack0, b_ack0, b_err0, ram_we0, ram_cs0;
  logic [15:0] a_dat1, b_dat1, ram_addr1, ram_dat1, rdat1;
  logic        a_ack1, b_ack1, b_err1, ram_we1, ram_cs1;

  logic [15:0] mem0 [0:32767];
  logic [15:0] mem1 [0:32767];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ram_arbiter #(.PRIO_MODE(0)) u0 (
    .i_clk(clk), .i_reset(reset),
    .i_a_req(a_req), .i_a_we(a_we), .i_a_addr(a_addr), .i_a_dat(a_dat),
    .o_a_dat(a_dat0), .o_a_ack(a_ack0),
    .i_b_req(b_req), .i_b_we(b_we), .i_b_addr(b_addr), .i_b_dat(b_dat),
    .o_b_dat(b_dat0), .o_b_ack(b_ack0), .o_b_err(b_err0),
    .o_ram_addr(ram_addr0), .o_ram_dat(ram_dat0), .o_ram_we(ram_we0),
    .o_ram_cs(ram_cs0), .i_ram_dat(rdat0)
  );

  ram_arbiter #(.PRIO_MODE(1)) u1 (
    .i_clk(clk), .i_reset(reset),
    .i_a_req(a_req), .i_a_we(a_we), .i_a_addr(a_addr), .i_a_dat(a_dat),
    .o_a_dat(a_dat1), .o_a_ack(a_ack1),
    .i_b_req(b_req), .i_b_we(b_we), .i_b_addr(b_addr), .i_b_dat(b_dat),
    .o_b_dat(b_dat1), .o_b_ack(b_ack1), .o_b_err(b_err1),
    .o_ram_addr(ram_addr1), .o_ram_dat(ram_dat1), .o_ram_we(ram_we1),
    .o_ram_cs(ram_cs1), .i_ram_dat(rdat1)
  );

  // RAM models: word array indexed by addr[15:1], pattern-filled so unwritten words are index+0x1000.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 32768; i++) begin
        mem0[i] <= 16'(i) + 16'h1000;
        mem1[i] <= 16'(i) + 16'h1000;
      end
    end else begin
      if (ram_cs0) begin
        if (ram_we0) mem0[ram_addr0[15:1]] <= ram_dat0;
        rdat0 <= mem0[ram_addr0[15:1]];
      end
      if (ram_cs1) begin
        if (ram_we1) mem1[ram_addr1[15:1]] <= ram_dat1;
        rdat1 <= mem1[ram_addr1[15:1]];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    tick();
    tick();
    mem_init = 1'b0;
    chk("rst_cs", {31'd0, ram_cs0}, 32'd0);
    chk("rst_we", {31'd0, ram_we0}, 32'd0);
    chk("rst_addr", {16'd0, ram_addr0}, 32'd0);
    chk("rst_wdat", {16'd0, ram_dat0}, 32'd0);
    chk("rst_acks", {30'd0, a_ack0, b_ack0}, 32'd0);
    chk("rst_dats", {a_dat0, b_dat0}, 32'd0);
    chk("rst_err", {31'd0, b_err0}, 32'd0);
    reset = 1'b0;

    // A write 0x1234 -> 0x0010, then A read back.
    a_req = 1'b1; a_we = 1'b1; a_addr = 16'h0010; a_dat = 16'h1234;
    tick();
    chk("wr_access_csweack", {29'd0, ram_cs0, ram_we0, a_ack0}, 32'b110);
    chk("wr_access_addr_dat", {ram_addr0, ram_dat0}, 32'h0010_1234);
    tick();
    chk("wr_wait_csweack", {29'd0, ram_cs0, ram_we0, a_ack0}, 32'b000);
    tick();
    chk("wr_ack", {30'd0, a_ack0, b_ack0}, 32'b10);
    a_we = 1'b0;
    tick();
    chk("rd_access_cswe", {30'd0, ram_cs0, ram_we0}, 32'b10);
    tick();
    chk("rd_wait_ack", {31'd0, a_ack0}, 32'd0);
    tick();
    chk("rd_ack", {31'd0, a_ack0}, 32'd1);
    chk("rd_dat", {16'd0, a_dat0}, 32'h1234);
    chk("rd_dat_u1", {15'd0, a_ack1, a_dat1}, 32'h1_1234);

    // Reset while a read is in WAIT: no ack, outputs cleared.
    tick();
    tick();
    reset = 1'b1;
    a_req = 1'b0;
    tick();
    chk("midrst_cs_we_acks", {28'd0, ram_cs0, ram_we0, a_ack0, b_ack0}, 32'd0);
    chk("midrst_dats", {a_dat0, b_dat0}, 32'd0);
    chk("midrst_addr", {16'd0, ram_addr0}, 32'd0);
    reset = 1'b0;
    tick();
    chk("midrst_no_late_ack", {31'd0, a_ack0}, 32'd0);

    // Both held: u0 alternates A,B starting with A; u1 serves only A.
    a_req = 1'b1; a_we = 1'b0; a_addr = 16'h0010;
    b_req = 1'b1; b_we = 1'b0; b_addr = 16'h0020;
    for (int c = 1; c <= 12; c++) begin
      tick();
      chk($sformatf("rr_a_c%0d", c), {31'd0, a_ack0}, {31'd0, (c == 3 || c == 9)});
      chk($sformatf("rr_b_c%0d", c), {31'd0, b_ack0}, {31'd0, (c == 6 || c == 12)});
      chk($sformatf("pr_ab_c%0d", c), {30'd0, a_ack1, b_ack1}, {30'd0, (c % 3 == 0), 1'b0});
      if (c == 3) chk("rr_a_dat", {16'd0, a_dat0}, 32'h1234);
      if (c == 6) chk("rr_b_dat", {16'd0, b_dat0}, 32'h1010);
    end
    a_req = 1'b0;
    tick();
    tick();
    chk("pr_b_waiting", {31'd0, b_ack1}, 32'd0);
    tick();
    chk("pr_b_served", {30'd0, a_ack1, b_ack1}, 32'b01);
    chk("pr_b_dat", {16'd0, b_dat1}, 32'h1010);
    chk("rr_b_again", {30'd0, a_ack0, b_ack0}, 32'b01);

    // B write 0xBEEF -> 0xF002, then A reads it back.
    b_we = 1'b1; b_addr = 16'hF002; b_dat = 16'hBEEF;
    tick();
`ifdef RAM_ARB_WPROT_EN
    chk("wp_access_cswe", {30'd0, ram_cs0, ram_we0}, 32'b00);
`else
    chk("wp_access_cswe", {30'd0, ram_cs0, ram_we0}, 32'b11);
`endif
    chk("wp_access_addr", {16'd0, ram_addr0}, 32'hF002);
    tick();
    tick();
`ifdef RAM_ARB_WPROT_EN
    chk("wp_ack_err", {30'd0, b_ack0, b_err0}, 32'b11);
`else
    chk("wp_ack_err", {30'd0, b_ack0, b_err0}, 32'b10);
`endif
    b_req = 1'b0;
    a_req = 1'b1; a_we = 1'b0; a_addr = 16'hF002;
    tick();
    chk("wp_err_pulse", {31'd0, b_err0}, 32'd0);
    tick();
    tick();
    a_req = 1'b0;
    chk("wp_rd_ack", {31'd0, a_ack0}, 32'd1);
`ifdef RAM_ARB_WPROT_EN
    chk("wp_rd_dat", {16'd0, a_dat0}, 32'h8801);
`else
    chk("wp_rd_dat", {16'd0, a_dat0}, 32'hBEEF);
`endif
    tick();
    chk("idle_after", {29'd0, ram_cs0, a_ack0, b_ack0}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
